// File: rtl/acc_unit_pkg.sv
// Shared types for the accumulator unit: rotate FSM states and direction codes.
// Used by acc_unit and acc_unit_rot_ctrl (optional SUB op is enabled with ACC_UNIT_SUB_EN).
package acc_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rot_state_e;

    localparam logic ROT_RIGHT = 1'b0;
    localparam logic ROT_LEFT  = 1'b1;

endpackage

// File: rtl/acc_unit_rot_ctrl.sv
// Multi-cycle rotate sequencer: counts steps and drives one step strobe per RUN cycle.
// Independent of ACC_UNIT_SUB_EN.
module acc_unit_rot_ctrl
    import acc_unit_pkg::*;
#(
    parameter int CNTW = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_clr,
    input  logic [CNTW-1:0] i_amt,
    input  logic            i_dir,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_step,
    output logic            o_step_dir,
    output rot_state_e      o_state
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    rot_state_e      r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_dir;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= ROT_RIGHT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= i_amt;
                        r_dir   <= i_dir;
                        r_state <= (i_amt != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    // CLR aborts the rotate without a completion pulse
                    if (i_clr) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = (r_state == ST_RUN);
    assign o_done     = (r_state == ST_DONE);
    assign o_step     = (r_state == ST_RUN) && !i_clr;
    assign o_step_dir = r_dir;
    assign o_state    = r_state;

endmodule

// File: rtl/acc_unit.sv
// Accumulator datapath with single-cycle ops and a multi-cycle rotate through E.
// Define ACC_UNIT_SUB_EN to add the SUB strobe ({E,AC} <= AC - DR, E=1 means no borrow).
module acc_unit
    import acc_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             CLR,
    input  logic             LD,
    input  logic             INR,
    input  logic             AND,
    input  logic             ADD,
    input  logic             CMA,
    input  logic             CME,
    input  logic             CLE,
    input  logic             CIR,
    input  logic             CIL,
`ifdef ACC_UNIT_SUB_EN
    input  logic             SUB,
`endif
    input  logic [WIDTH-1:0] inAC,
    input  logic [WIDTH-1:0] DR,
    input  logic             ROTGO,
    input  logic [CNTW-1:0]  ROTAMT,
    input  logic             ROTDIR,
    output logic [WIDTH-1:0] AC,
    output logic             E,
    output logic             Z,
    output logic             N,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [WIDTH:0] EXT_ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_ac;
    logic             r_e;

    logic [WIDTH-1:0] w_ac_nxt;
    logic             w_e_nxt;
    logic             w_rot_start;
    logic             w_step;
    logic             w_step_dir;
    logic             w_idle;
    rot_state_e       w_rot_state;

    acc_unit_rot_ctrl #(
        .CNTW (CNTW)
    ) u_rot_ctrl (
        .i_clk      (CLK),
        .i_rst_n    (RSTn),
        .i_start    (w_rot_start),
        .i_clr      (CLR),
        .i_amt      (ROTAMT),
        .i_dir      (ROTDIR),
        .o_busy     (BUSY),
        .o_done     (DONE),
        .o_step     (w_step),
        .o_step_dir (w_step_dir),
        .o_state    (w_rot_state)
    );

    assign w_idle = (w_rot_state == ST_IDLE);

    // CLR wins in every state; everything else only from IDLE, first strobe in priority order.
    always_comb begin
        w_ac_nxt    = r_ac;
        w_e_nxt     = r_e;
        w_rot_start = 1'b0;
        if (CLR) begin
            w_ac_nxt = '0;
        end else if (w_step) begin
            if (w_step_dir == ROT_LEFT) begin
                {w_e_nxt, w_ac_nxt} = {r_ac, r_e};
            end else begin
                {w_ac_nxt, w_e_nxt} = {r_e, r_ac};
            end
        end else if (w_idle) begin
            if (LD) begin
                w_ac_nxt = inAC;
            end else if (INR) begin
                {w_e_nxt, w_ac_nxt} = {1'b0, r_ac} + EXT_ONE;
            end else if (AND) begin
                w_ac_nxt = r_ac & DR;
            end else if (ADD) begin
                {w_e_nxt, w_ac_nxt} = {1'b0, r_ac} + {1'b0, DR};
`ifdef ACC_UNIT_SUB_EN
            end else if (SUB) begin
                {w_e_nxt, w_ac_nxt} = {1'b0, r_ac} + {1'b0, ~DR} + EXT_ONE;
`endif
            end else if (CMA) begin
                w_ac_nxt = ~r_ac;
            end else if (CME) begin
                w_e_nxt = ~r_e;
            end else if (CLE) begin
                w_e_nxt = 1'b0;
            end else if (CIR) begin
                {w_ac_nxt, w_e_nxt} = {r_e, r_ac};
            end else if (CIL) begin
                {w_e_nxt, w_ac_nxt} = {r_ac, r_e};
            end else if (ROTGO) begin
                w_rot_start = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ac <= '0;
            r_e  <= 1'b0;
        end else begin
            r_ac <= w_ac_nxt;
            r_e  <= w_e_nxt;
        end
    end

    assign AC = r_ac;
    assign E  = r_e;
    assign Z  = (r_ac == '0);
    assign N  = r_ac[WIDTH-1];

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit at WIDTH=16; SUB vectors run when ACC_UNIT_SUB_EN is defined.
module tb_acc_unit;

    localparam int WIDTH = 16;
    localparam int CNTW  = $clog2(WIDTH) + 1;

    logic             CLK;
    logic             RSTn;
    logic             CLR, LD, INR, AND, ADD, CMA, CME, CLE, CIR, CIL;
`ifdef ACC_UNIT_SUB_EN
    logic             SUB;
`endif
    logic [WIDTH-1:0] inAC;
    logic [WIDTH-1:0] DR;
    logic             ROTGO;
    logic [CNTW-1:0]  ROTAMT;
    logic             ROTDIR;
    logic [WIDTH-1:0] AC;
    logic             E, Z, N, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    acc_unit #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .CLR    (CLR),
        .LD     (LD),
        .INR    (INR),
        .AND    (AND),
        .ADD    (ADD),
        .CMA    (CMA),
        .CME    (CME),
        .CLE    (CLE),
        .CIR    (CIR),
        .CIL    (CIL),
`ifdef ACC_UNIT_SUB_EN
        .SUB    (SUB),
`endif
        .inAC   (inAC),
        .DR     (DR),
        .ROTGO  (ROTGO),
        .ROTAMT (ROTAMT),
        .ROTDIR (ROTDIR),
        .AC     (AC),
        .E      (E),
        .Z      (Z),
        .N      (N),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    // clock / watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        CLR = 0; LD = 0; INR = 0; AND = 0; ADD = 0; CMA = 0;
        CME = 0; CLE = 0; CIR = 0; CIL = 0;
`ifdef ACC_UNIT_SUB_EN
        SUB = 0;
`endif
        ROTGO = 0; ROTAMT = '0; ROTDIR = 0;
        inAC = '0; DR = '0;
    endtask

    task automatic do_ld(input logic [WIDTH-1:0] v);
        LD = 1; inAC = v; tick(); LD = 0; inAC = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input string tag, input logic [WIDTH-1:0] ac_e, input logic e_e);
        check({tag, "_ac"}, 64'(AC), 64'(ac_e));
        check({tag, "_e"}, 64'(E), 64'(e_e));
    endtask

    int busy_cnt;
    int guard;

    initial begin
        idle_inputs();
        RSTn = 1;
        #2 RSTn = 0;
        #2;
        check_state("reset", 16'h0000, 1'b0);
        check("reset_z", 64'(Z), 64'd1);
        check("reset_n", 64'(N), 64'd0);
        check("reset_busy", 64'(BUSY), 64'd0);
        check("reset_done", 64'(DONE), 64'd0);
        tick();
        RSTn = 1;

        // wrap and arithmetic
        do_ld(16'hFFFF);
        check("ld_n", 64'(N), 64'd1);
        INR = 1; tick(); INR = 0;
        check_state("inr_wrap", 16'h0000, 1'b1);
        check("inr_wrap_z", 64'(Z), 64'd1);
        CLE = 1; tick(); CLE = 0;
        check("cle_e", 64'(E), 64'd0);
        do_ld(16'h8000);
        ADD = 1; DR = 16'h0001; tick(); ADD = 0;
        check_state("add_nocarry", 16'h8001, 1'b0);
        check("add_nocarry_n", 64'(N), 64'd1);
        do_ld(16'hFFFF);
        ADD = 1; DR = 16'h0002; tick(); ADD = 0;
        check_state("add_carry", 16'h0001, 1'b1);
        do_ld(16'hF0F0);
        AND = 1; DR = 16'h3C3C; tick(); AND = 0;
        check_state("and", 16'h3030, 1'b1);
        CMA = 1; tick(); CMA = 0;
        check_state("cma", 16'hCFCF, 1'b1);
        CME = 1; tick(); CME = 0;
        check_state("cme", 16'hCFCF, 1'b0);
        CIR = 1; tick(); CIR = 0;
        check_state("cir", 16'h67E7, 1'b1);
        CIL = 1; tick(); CIL = 0;
        check_state("cil", 16'hCFCF, 1'b0);

        // priority
        do_ld(16'h1234);
        CLR = 1; LD = 1; inAC = 16'hBEEF; tick(); CLR = 0; LD = 0;
        check_state("prio_clr_ld", 16'h0000, 1'b0);
        LD = 1; INR = 1; inAC = 16'h00AA; tick(); LD = 0; INR = 0;
        check_state("prio_ld_inr", 16'h00AA, 1'b0);
        CMA = 1; CME = 1; tick(); CMA = 0; CME = 0;
        check_state("prio_cma_cme", 16'hFF55, 1'b0);
        CMA = 1; ROTGO = 1; ROTAMT = 5'd3; tick(); CMA = 0; ROTGO = 0;
        check_state("prio_cma_rotgo", 16'h00AA, 1'b0);
        check("prio_rotgo_dropped_busy", 64'(BUSY), 64'd0);
        tick();
        check("prio_rotgo_dropped_done", 64'(DONE), 64'd0);

        // rotate by 1, right
        do_ld(16'h0001);
        ROTGO = 1; ROTAMT = 5'd1; ROTDIR = 0; tick(); ROTGO = 0;
        check("rot1_busy", 64'(BUSY), 64'd1);
        check("rot1_done_early", 64'(DONE), 64'd0);
        check("rot1_ac_hold", 64'(AC), 64'h0001);
        tick();
        check("rot1_busy_end", 64'(BUSY), 64'd0);
        check("rot1_done", 64'(DONE), 64'd1);
        check_state("rot1", 16'h0000, 1'b1);
        tick();
        check("rot1_done_pulse", 64'(DONE), 64'd0);

        // rotate by 3, right
        do_ld(16'h0001);
        CLE = 1; tick(); CLE = 0;
        ROTGO = 1; ROTAMT = 5'd3; ROTDIR = 0; tick(); ROTGO = 0;
        busy_cnt = 0; guard = 0;
        while (BUSY && guard < 100) begin busy_cnt++; tick(); guard++; end
        check("rot3_busy_cycles", 64'(busy_cnt), 64'd3);
        check("rot3_done", 64'(DONE), 64'd1);
        check_state("rot3", 16'h4000, 1'b0);
        tick();

        // rotate by 2, left
        do_ld(16'h8000);
        ROTGO = 1; ROTAMT = 5'd2; ROTDIR = 1; tick(); ROTGO = 0;
        tick();
        check_state("rotl_step1", 16'h0000, 1'b1);
        tick();
        check("rotl_done", 64'(DONE), 64'd1);
        check_state("rotl", 16'h0001, 1'b0);
        tick();

        // 17-step rotate restores value; other strobes ignored while running
        do_ld(16'hA5C3);
        CME = 1; tick(); CME = 0;
        ROTGO = 1; ROTAMT = 5'd17; ROTDIR = 1; tick();
        LD = 1; INR = 1; CMA = 1; inAC = 16'hFFFF;
        busy_cnt = 0; guard = 0;
        while (BUSY && guard < 100) begin
            busy_cnt++;
            if (busy_cnt == 5) begin LD = 0; INR = 0; CMA = 0; ROTGO = 0; end
            tick();
            guard++;
        end
        LD = 0; INR = 0; CMA = 0; ROTGO = 0;
        check("rot17_busy_cycles", 64'(busy_cnt), 64'd17);
        check("rot17_done", 64'(DONE), 64'd1);
        check_state("rot17", 16'hA5C3, 1'b1);
        ROTGO = 1; ROTAMT = 5'd3; tick(); ROTGO = 0;
        check("rotgo_in_done_busy", 64'(BUSY), 64'd0);
        check("rotgo_in_done_done", 64'(DONE), 64'd0);
        tick();
        check("rotgo_not_queued", 64'(BUSY), 64'd0);

        // zero count
        ROTGO = 1; ROTAMT = 5'd0; ROTDIR = 0; tick(); ROTGO = 0;
        check("rot0_busy", 64'(BUSY), 64'd0);
        check("rot0_done", 64'(DONE), 64'd1);
        check_state("rot0", 16'hA5C3, 1'b1);
        tick();
        check("rot0_done_pulse", 64'(DONE), 64'd0);

        // CLR aborts a running rotate
        do_ld(16'h1235);
        CLE = 1; tick(); CLE = 0;
        ROTGO = 1; ROTAMT = 5'd5; ROTDIR = 0; tick(); ROTGO = 0;
        tick();
        check("clr_run_busy", 64'(BUSY), 64'd1);
        check_state("clr_run_step", 16'h091A, 1'b1);
        CLR = 1; tick(); CLR = 0;
        check_state("clr_run", 16'h0000, 1'b1);
        check("clr_run_busy_off", 64'(BUSY), 64'd0);
        check("clr_run_no_done", 64'(DONE), 64'd0);
        tick();
        check("clr_run_no_done_late", 64'(DONE), 64'd0);

        // asynchronous reset mid-rotate
        do_ld(16'h1234);
        ROTGO = 1; ROTAMT = 5'd5; ROTDIR = 0; tick(); ROTGO = 0;
        tick();
        check_state("rst_run_step", 16'h891A, 1'b0);
        check("rst_run_n_pre", 64'(N), 64'd1);
        RSTn = 0;
        #1;
        check_state("rst_run", 16'h0000, 1'b0);
        check("rst_run_busy", 64'(BUSY), 64'd0);
        check("rst_run_done", 64'(DONE), 64'd0);
        check("rst_run_z", 64'(Z), 64'd1);
        check("rst_run_n", 64'(N), 64'd0);
        tick();
        RSTn = 1;
        do_ld(16'h0055);
        check_state("post_reset_ld", 16'h0055, 1'b0);
        check("post_reset_busy", 64'(BUSY), 64'd0);

`ifdef ACC_UNIT_SUB_EN
        do_ld(16'h0005);
        SUB = 1; DR = 16'h0007; tick(); SUB = 0;
        check_state("sub_borrow", 16'hFFFE, 1'b0);
        do_ld(16'h0007);
        SUB = 1; DR = 16'h0005; tick(); SUB = 0;
        check_state("sub_noborrow", 16'h0002, 1'b1);
        SUB = 1; CMA = 1; DR = 16'h0002; tick(); SUB = 0; CMA = 0;
        check_state("prio_sub_cma", 16'h0000, 1'b1);
`endif

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
